hyperbus_target: RTL and testbench
==================================

// Module: hyperbus_target
// PURPOSE
//  Synthesizable HyperBus device-side responder: the memory end of the link hyper_xface drives.
//  Decodes the 48-bit CA phase, counts fixed 2x initial latency, serves DDR read/write bursts
//  out of a 16-bit word SRAM port, and answers register-space accesses (ID0, CR0).
//  Replaces the s27ks0641 model in FPGA loopback builds; clk runs at exactly 2x dram_ck.
// PARAMETERS
//  ADDR_W       22       word address width presented on mem_addr
//  LATENCY      6        initial latency in dram_ck cycles (always applied doubled)
//  WRAP_WORDS   16       wrapped-burst group size in words (power of 2)
//  ID0_VAL      16'h0C81 value returned for register read, addr[11]=0
//  CR0_DEFAULT  16'h8F1F CR0 value after reset
// PORTS
//  clk            in   1      system clock, 2x dram_ck
//  reset_l        in   1      synchronous active-low reset
//  dram_ck        in   1      HyperBus clock from controller
//  dram_cs_l      in   1      chip select, active low
//  dram_rst_l     in   1      HyperBus reset, active low
//  dram_dq_in     in   8      DQ sampled from controller
//  dram_dq_out    out  8      DQ driven to controller
//  dram_dq_oe_l   out  1      DQ output enable, active low
//  dram_rwds_in   in   1      RWDS from controller (write byte mask, 1=masked)
//  dram_rwds_out  out  1      RWDS driven by target
//  dram_rwds_oe_l out  1      RWDS output enable, active low
//  mem_addr       out  ADDR_W SRAM word address
//  mem_rd_req     out  1      SRAM read strobe; mem_rd_d valid next clk
//  mem_rd_d       in   16     SRAM read data
//  mem_wr_req     out  1      SRAM write strobe, single clk
//  mem_wr_d       out  16     SRAM write data
//  mem_wr_be      out  2      byte enables {[15:8],[7:0]}
//  cfg_cr0        out  16     current CR0 contents
// BEHAVIOUR
//  Reset (reset_l=0 or dram_rst_l=0 at clk): state IDLE; dq_out=0, dq_oe_l=1, rwds_out=0,
//   rwds_oe_l=1, mem_* strobes/addr/data/be=0, cfg_cr0=CR0_DEFAULT.
//  Edge event: ck_q<=dram_ck each clk; edge when dram_ck!=ck_q; dq/rwds sampled that clk.
//  dram_cs_l=1 in any state -> IDLE next clk, both oe_l=1; incomplete write word discarded.
//  IDLE: cs_l falls -> CA. CA: shift 6 bytes MSB first over 6 edges; rwds_oe_l=0, rwds_out=1.
//   CA[47]=read, CA[46]=register space, CA[45]=linear burst (0=wrapped).
//   word addr = {CA[44:16],CA[2:0]} truncated to ADDR_W.
//  After 6th edge: reg write -> REG_WR (zero latency); else LAT, count 4*LATENCY-4 edges.
//  LAT: read: rwds_oe_l=0, rwds_out=0; write: rwds_oe_l=1. Then RD or WR.
//  WR: 2 edges/word, first byte=[15:8]; be bit=~rwds_in per byte; mem_wr_req pulses clk after
//   2nd byte with addr,d,be; be=00 still pulses. Address advances after each word.
//  RD: dq_oe_l=0; per word, edge1 drives [15:8] with rwds_out=1, edge2 [7:0] with rwds_out=0.
//   mem_rd_req for word N issued >=1 clk before its first edge (first word during last LAT clk).
//  REG_WR: 2 edges -> cfg_cr0={b0,b1} if addr[11]=1, else ignored; then HOLD.
//  Reg read: data=addr[11]?cfg_cr0:ID0_VAL, repeated every word; no mem_rd_req.
//  Burst ends only on cs_l=1 (HOLD ignores edges until then).
//  Linear addr wraps 2^ADDR_W-1 -> 0. Wrapped: low log2(WRAP_WORDS) bits increment, high fixed.
// TESTING
//  Write CA 0x200000000003, 4 words 1111..4444, rwds=0 -> mem_wr at 3,4,5,6 with be=11.
//  Read linear from 3 with SRAM=addr value -> DQ 00,03,00,04,00,05; rwds toggles 1/0.
//  Wrapped read CA[45]=0 from word 14, 4 words -> addrs 14,15,0,1.
//  Write byte 2 rwds=1 -> mem_wr_be=01; cs_l raised after 1 byte -> no mem_wr_req.
//  Reg write CR0 addr[11]=1 data 8F17 -> cfg_cr0=8F17; reg read addr 0 -> 0C81.
//  reset_l=0 mid-read -> next clk dq_oe_l=1, rwds_oe_l=1, IDLE; new CA accepted after.

Source files
------------

// File: rtl/hyperbus_target.sv
// HyperBus device-side responder: decodes the CA phase, applies doubled initial latency and
// serves DDR bursts from a 16-bit word SRAM port or the ID0/CR0 register space.
module hyperbus_target #(
  parameter int          ADDR_W      = 22,
  parameter int          LATENCY     = 6,
  parameter int          WRAP_WORDS  = 16,
  parameter logic [15:0] ID0_VAL     = 16'h0C81,
  parameter logic [15:0] CR0_DEFAULT = 16'h8F1F
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              dram_ck,
  input  logic              dram_cs_l,
  input  logic              dram_rst_l,
  input  logic [7:0]        dram_dq_in,
  output logic [7:0]        dram_dq_out,
  output logic              dram_dq_oe_l,
  input  logic              dram_rwds_in,
  output logic              dram_rwds_out,
  output logic              dram_rwds_oe_l,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic [15:0]       mem_rd_d,
  output logic              mem_wr_req,
  output logic [15:0]       mem_wr_d,
  output logic [1:0]        mem_wr_be,
  output logic [15:0]       cfg_cr0
);

  localparam int         WB       = $clog2(WRAP_WORDS);
  localparam logic [7:0] LAT_LAST = 8'(4 * LATENCY - 5);
  localparam logic [7:0] LAT_PRE  = 8'(4 * LATENCY - 6);

  typedef enum logic [2:0] {IDLE, CA, LAT, WR, RD, REG_WR, HOLD} state_t;

  state_t            state;
  logic              ck_q, phase, is_read, is_reg, linear, be_hi;
  logic [7:0]        cnt, wr_hi, rd_lo;
  logic [39:0]       ca_sr;
  logic [ADDR_W-1:0] addr;

  logic              edge_ev, rst;
  logic [47:0]       ca_full;
  logic [31:0]       ca_addr_w;
  logic [ADDR_W-1:0] ca_addr, addr_inc, addr_nxt;
  logic [15:0]       rd_word;
  logic              unused_ca;

  assign edge_ev   = dram_ck ^ ck_q;
  assign rst       = !reset_l || !dram_rst_l;
  assign ca_full   = {ca_sr, dram_dq_in};
  assign ca_addr_w = {ca_full[44:16], ca_full[2:0]};
  assign ca_addr   = ca_addr_w[ADDR_W-1:0];
  assign unused_ca = ^{ca_addr_w[31:ADDR_W], ca_full[15:3]};

  // Wrapped bursts only advance the low bits; the group base stays put.
  assign addr_inc = addr + ADDR_W'(1);
  assign addr_nxt = linear ? addr_inc : {addr[ADDR_W-1:WB], addr_inc[WB-1:0]};
  assign rd_word  = is_reg ? (addr[11] ? cfg_cr0 : ID0_VAL) : mem_rd_d;

  // SRAM port: a one-clk mem_rd_req latches mem_addr and mem_rd_d is valid from the next clk
  // until the following request; mem_wr_req is a one-clk strobe qualifying addr/data/be.
  always_ff @(posedge clk) begin
    ck_q <= dram_ck;
    if (rst) begin
      state          <= IDLE;
      dram_dq_out    <= '0;
      dram_dq_oe_l   <= 1'b1;
      dram_rwds_out  <= 1'b0;
      dram_rwds_oe_l <= 1'b1;
      mem_addr       <= '0;
      mem_rd_req     <= 1'b0;
      mem_wr_req     <= 1'b0;
      mem_wr_d       <= '0;
      mem_wr_be      <= '0;
      cfg_cr0        <= CR0_DEFAULT;
      phase          <= 1'b0;
      is_read        <= 1'b0;
      is_reg         <= 1'b0;
      linear         <= 1'b0;
      be_hi          <= 1'b0;
      cnt            <= '0;
      wr_hi          <= '0;
      rd_lo          <= '0;
      ca_sr          <= '0;
      addr           <= '0;
    end else begin
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      if (dram_cs_l) begin
        state          <= IDLE;
        dram_dq_out    <= '0;
        dram_dq_oe_l   <= 1'b1;
        dram_rwds_out  <= 1'b0;
        dram_rwds_oe_l <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state          <= CA;
            dram_rwds_oe_l <= 1'b0;
            dram_rwds_out  <= 1'b1;
            ca_sr          <= {ca_sr[31:0], dram_dq_in};
            cnt            <= edge_ev ? 8'd1 : 8'd0;
          end
          CA: if (edge_ev) begin
            ca_sr <= {ca_sr[31:0], dram_dq_in};
            cnt   <= cnt + 8'd1;
            if (cnt == 8'd5) begin
              is_read <= ca_full[47];
              is_reg  <= ca_full[46];
              linear  <= ca_full[45];
              addr    <= ca_addr;
              cnt     <= '0;
              phase   <= 1'b0;
              if (!ca_full[47] && ca_full[46]) begin
                state          <= REG_WR;
                dram_rwds_oe_l <= 1'b1;
              end else begin
                state          <= LAT;
                dram_rwds_oe_l <= !ca_full[47];
                dram_rwds_out  <= 1'b0;
              end
            end
          end
          LAT: if (edge_ev) begin
            if (cnt == LAT_LAST) begin
              state <= is_read ? RD : WR;
              if (is_read) dram_dq_oe_l <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
            // Fetch the first word early enough that it is on mem_rd_d at the first data edge.
            if (cnt == LAT_PRE && is_read && !is_reg) begin
              mem_rd_req <= 1'b1;
              mem_addr   <= addr;
              addr       <= addr_nxt;
            end
          end
          RD: if (edge_ev) begin
            if (!phase) begin
              dram_dq_out   <= rd_word[15:8];
              rd_lo         <= rd_word[7:0];
              dram_rwds_out <= 1'b1;
              phase         <= 1'b1;
              if (!is_reg) begin
                mem_rd_req <= 1'b1;
                mem_addr   <= addr;
                addr       <= addr_nxt;
              end
            end else begin
              dram_dq_out   <= rd_lo;
              dram_rwds_out <= 1'b0;
              phase         <= 1'b0;
            end
          end
          WR: if (edge_ev) begin
            if (!phase) begin
              wr_hi <= dram_dq_in;
              be_hi <= !dram_rwds_in;
              phase <= 1'b1;
            end else begin
              mem_wr_req <= 1'b1;
              mem_addr   <= addr;
              mem_wr_d   <= {wr_hi, dram_dq_in};
              mem_wr_be  <= {be_hi, !dram_rwds_in};
              addr       <= addr_nxt;
              phase      <= 1'b0;
            end
          end
          REG_WR: if (edge_ev) begin
            if (!phase) begin
              wr_hi <= dram_dq_in;
              phase <= 1'b1;
            end else begin
              if (addr[11]) cfg_cr0 <= {wr_hi, dram_dq_in};
              state <= HOLD;
            end
          end
          HOLD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_target.sv
// Bench for hyperbus_target: a transaction-level HyperBus controller driver, an SRAM model,
// and a reference model of addresses, data bytes and pin enables checked every clock.
module tb_hyperbus_target;
  localparam int AW  = 22;
  localparam int LAT = 6;

  logic          clk, reset_l, dram_ck, dram_cs_l, dram_rst_l;
  logic [7:0]    dram_dq_in, dram_dq_out;
  logic          dram_dq_oe_l, dram_rwds_in, dram_rwds_out, dram_rwds_oe_l;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_req, mem_wr_req;
  logic [15:0]   mem_rd_d, mem_wr_d, cfg_cr0;
  logic [1:0]    mem_wr_be;

  hyperbus_target dut (
    .clk(clk), .reset_l(reset_l), .dram_ck(dram_ck), .dram_cs_l(dram_cs_l),
    .dram_rst_l(dram_rst_l), .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out),
    .dram_dq_oe_l(dram_dq_oe_l), .dram_rwds_in(dram_rwds_in), .dram_rwds_out(dram_rwds_out),
    .dram_rwds_oe_l(dram_rwds_oe_l), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_rd_d(mem_rd_d), .mem_wr_req(mem_wr_req), .mem_wr_d(mem_wr_d),
    .mem_wr_be(mem_wr_be), .cfg_cr0(cfg_cr0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [15:0]   sram_salt = 16'h0000;
  logic [15:0]   cr0_m = 16'h8F1F;
  bit            ca_rand = 1'b0;
  logic [15:0]   wdat [0:7];
  logic [1:0]    wmsk [0:7];
  logic [39:0]   exp_wr_q[$];
  logic [39:0]   cap_wr[$];
  logic [7:0]    cap_dq[$];
  logic [AW-1:0] cap_ra[$];
  bit            rd_track = 1'b0;
  bit            rd_lin   = 1'b0;
  logic [AW-1:0] rd_start = '0;
  int            rd_k     = 0;

  bit            exp_on = 1'b0;
  logic          exp_dq_oe_l, exp_rwds_oe_l, exp_rwds;
  bit            exp_rwds_chk, exp_dq_chk;
  logic [7:0]    exp_dq;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
  endtask

  function automatic logic [15:0] sram_fn(input logic [AW-1:0] a);
    return 16'(a) ^ sram_salt;
  endfunction

  // Address of the k-th word of a burst starting at s.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] s, input int k, input bit lin);
    int unsigned base;
    base = int'(s);
    if (lin) return AW'((base + k) % (1 << AW));
    return AW'((base / 16) * 16 + (base % 16 + k) % 16);
  endfunction

  task automatic set_exp(input bit on, input logic dq_oe, input logic rwds_oe, input bit rwds_c,
                         input logic rwds_v, input bit dq_c, input logic [7:0] dq_v);
    exp_on = on; exp_dq_oe_l = dq_oe; exp_rwds_oe_l = rwds_oe;
    exp_rwds_chk = rwds_c; exp_rwds = rwds_v; exp_dq_chk = dq_c; exp_dq = dq_v;
  endtask

  // SRAM: latches the request address and holds the data until the next request.
  initial mem_rd_d = 16'h0000;
  always @(posedge clk) if (mem_rd_req) mem_rd_d <= sram_fn(mem_addr);

  // ---------------- scoreboard / compare process ----------------
  always begin
    logic [39:0] e;
    @(posedge clk);
    #1;
    if (exp_on) begin
      chk("dq_oe_l", dram_dq_oe_l, exp_dq_oe_l);
      chk("rwds_oe_l", dram_rwds_oe_l, exp_rwds_oe_l);
      if (exp_rwds_chk) chk("rwds_out", dram_rwds_out, exp_rwds);
      if (exp_dq_chk) begin
        chk("dq_out", dram_dq_out, exp_dq);
        cap_dq.push_back(dram_dq_out);
      end
    end
    if (mem_wr_req) begin
      cap_wr.push_back({mem_wr_be, mem_wr_d, mem_addr});
      if (exp_wr_q.size() == 0) chk("mem_wr_req_unexpected", mem_wr_req, 1'b0);
      else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", mem_addr, e[21:0]);
        chk("wr_data", mem_wr_d, e[37:22]);
        chk("wr_be", mem_wr_be, e[39:38]);
      end
    end
    if (mem_rd_req) begin
      cap_ra.push_back(mem_addr);
      if (!rd_track) chk("mem_rd_req_unexpected", mem_rd_req, 1'b0);
      else begin
        chk("rd_addr", mem_addr, model_addr(rd_start, rd_k, rd_lin));
        rd_k++;
      end
    end
  end

  // ---------------- driver ----------------
  // cut >= 0 stops the data phase after that many edges; rst_kind 0 = just deselect,
  // 1 = pulse reset_l, 2 = pulse dram_rst_l.
  task automatic hb_txn(input bit rd, input bit rg, input bit lin, input logic [AW-1:0] a,
                        input int nwords, input int cut, input int rst_kind);
    logic [47:0] ca;
    logic [15:0] d;
    int          nb;
    bit          cut_hit;
    ca = {rd, rg, lin, 10'(ca_rand ? $urandom : 0), a[21:3], 13'(ca_rand ? $urandom : 0), a[2:0]};
    rd_track = rd && !rg; rd_start = a; rd_lin = lin; rd_k = 0;
    @(negedge clk);
    dram_cs_l = 1'b0;
    set_exp(1, 1'b1, 1'b0, 1, 1'b1, 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dram_ck = ~dram_ck;
      dram_dq_in = ca[47-8*i -: 8];
      if (i < 5)   set_exp(1, 1'b1, 1'b0, 1, 1'b1, 0, 8'h00);
      else if (rd) set_exp(1, 1'b1, 1'b0, 1, 1'b0, 0, 8'h00);
      else         set_exp(1, 1'b1, 1'b1, 0, 1'b0, 0, 8'h00);
    end
    if (rd || !rg) begin
      for (int j = 0; j < 4*LAT-4; j++) begin
        @(negedge clk);
        dram_ck = ~dram_ck;
        dram_dq_in = 8'h00;
        if (rd && j == 4*LAT-5) set_exp(1, 1'b0, 1'b0, 1, 1'b0, 0, 8'h00);
        else if (rd)            set_exp(1, 1'b1, 1'b0, 1, 1'b0, 0, 8'h00);
        else                    set_exp(1, 1'b1, 1'b1, 0, 1'b0, 0, 8'h00);
      end
    end
    nb = (rg && !rd) ? 4 : 2*nwords;
    cut_hit = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == cut) begin
        cut_hit = 1'b1;
        break;
      end
      @(negedge clk);
      dram_ck = ~dram_ck;
      if (rd) begin
        d = rg ? (a[11] ? cr0_m : 16'h0C81) : sram_fn(model_addr(a, i/2, lin));
        dram_dq_in = 8'h00;
        set_exp(1, 1'b0, 1'b0, 1, (i % 2 == 0), 1, (i % 2 == 0) ? d[15:8] : d[7:0]);
      end else begin
        d = wdat[i/2];
        dram_dq_in = (i % 2 == 0) ? d[15:8] : d[7:0];
        dram_rwds_in = rg ? 1'b0 : ((i % 2 == 0) ? wmsk[i/2][1] : wmsk[i/2][0]);
        set_exp(1, 1'b1, 1'b1, 0, 1'b0, 0, 8'h00);
        if (i % 2 == 1 && !rg) exp_wr_q.push_back({~wmsk[i/2], d, model_addr(a, i/2, lin)});
        if (i == 1 && rg && a[11]) cr0_m = d;
      end
    end
    if (cut_hit && rst_kind != 0) begin
      @(negedge clk);
      if (rst_kind == 1) reset_l = 1'b0;
      else dram_rst_l = 1'b0;
      set_exp(1, 1'b1, 1'b1, 0, 1'b0, 0, 8'h00);
      rd_track = 1'b0;
      cr0_m = 16'h8F1F;
      @(negedge clk);
      chk("cr0_after_reset", cfg_cr0, 16'h8F1F);
      reset_l = 1'b1; dram_rst_l = 1'b1; dram_cs_l = 1'b1;
    end
    @(negedge clk);
    dram_cs_l = 1'b1; dram_dq_in = 8'h00; dram_rwds_in = 1'b0;
    set_exp(1, 1'b1, 1'b1, 0, 1'b0, 0, 8'h00);
    repeat (2) @(negedge clk);
    rd_track = 1'b0;
    chk("cfg_cr0", cfg_cr0, cr0_m);
    chk("wr_pending", exp_wr_q.size(), 0);
  endtask

  task automatic clear_caps();
    cap_dq.delete(); cap_wr.delete(); cap_ra.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] lit_w [0:3];
    logic [7:0]  lit_rd [0:5];
    logic [7:0]  lit_rg [0:3];
    logic [AW-1:0] lit_wa [0:3];
    int kind, nw, cut, rk;
    bit lin;
    logic [AW-1:0] a;
    lit_w  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    lit_rd = '{8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
    lit_rg = '{8'h0C, 8'h81, 8'h0C, 8'h81};
    lit_wa = '{22'd14, 22'd15, 22'd0, 22'd1};

    reset_l = 1'b0; dram_rst_l = 1'b1; dram_ck = 1'b0; dram_cs_l = 1'b1;
    dram_dq_in = 8'h00; dram_rwds_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dq_out", dram_dq_out, 8'h00);
    chk("rst_dq_oe_l", dram_dq_oe_l, 1'b1);
    chk("rst_rwds_out", dram_rwds_out, 1'b0);
    chk("rst_rwds_oe_l", dram_rwds_oe_l, 1'b1);
    chk("rst_mem_rd_req", mem_rd_req, 1'b0);
    chk("rst_mem_wr_req", mem_wr_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 22'h0);
    chk("rst_mem_wr_d", mem_wr_d, 16'h0);
    chk("rst_mem_wr_be", mem_wr_be, 2'b00);
    chk("rst_cfg_cr0", cfg_cr0, 16'h8F1F);
    reset_l = 1'b1;
    set_exp(1, 1'b1, 1'b1, 0, 1'b0, 0, 8'h00);
    repeat (2) @(negedge clk);

    // Linear write from word 3 (CA 0x200000000003)
    for (int i = 0; i < 4; i++) begin wdat[i] = lit_w[i]; wmsk[i] = 2'b00; end
    clear_caps();
    hb_txn(1'b0, 1'b0, 1'b1, 22'd3, 4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("dir_wr_addr", cap_wr[i][21:0], 22'(3 + i));
      chk("dir_wr_data", cap_wr[i][37:22], lit_w[i]);
      chk("dir_wr_be", cap_wr[i][39:38], 2'b11);
    end

    // Linear read from 3 with SRAM returning its own address
    sram_salt = 16'h0000;
    clear_caps();
    hb_txn(1'b1, 1'b0, 1'b1, 22'd3, 3, -1, 0);
    for (int i = 0; i < 6; i++) chk("dir_rd_dq", cap_dq[i], lit_rd[i]);

    // Wrapped read from word 14
    clear_caps();
    hb_txn(1'b1, 1'b0, 1'b0, 22'd14, 4, -1, 0);
    for (int i = 0; i < 4; i++) chk("dir_wrap_addr", cap_ra[i], lit_wa[i]);

    // Masked upper byte, then a write deselected after one byte
    wdat[0] = 16'hA55A; wmsk[0] = 2'b10;
    clear_caps();
    hb_txn(1'b0, 1'b0, 1'b1, 22'h10, 1, -1, 0);
    chk("dir_mask_be", cap_wr[0][39:38], 2'b01);
    clear_caps();
    hb_txn(1'b0, 1'b0, 1'b1, 22'h20, 1, 1, 0);
    chk("dir_abort_no_wr", cap_wr.size(), 0);

    // Register write to CR0, register read of ID0
    wdat[0] = 16'h8F17;
    hb_txn(1'b0, 1'b1, 1'b1, 22'h800, 1, -1, 0);
    chk("dir_cr0", cfg_cr0, 16'h8F17);
    clear_caps();
    hb_txn(1'b1, 1'b1, 1'b1, 22'h0, 2, -1, 0);
    for (int i = 0; i < 4; i++) chk("dir_id0_dq", cap_dq[i], lit_rg[i]);

    // Reset in the middle of a read, then a fresh transaction
    sram_salt = 16'h5A5A;
    hb_txn(1'b1, 1'b0, 1'b1, 22'h123, 4, 3, 1);
    hb_txn(1'b1, 1'b0, 1'b1, 22'h200, 2, -1, 0);

    // Randomized traffic
    ca_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      lin  = 1'($urandom_range(0, 1));
      nw   = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0:       a = AW'($urandom);
        1:       a = 22'h3FFFFC | AW'($urandom_range(0, 3));
        2:       a = {AW'($urandom)} | 22'hC;
        default: a = 22'h800 | AW'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 1) == 1) a[11] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        wdat[i] = 16'($urandom);
        wmsk[i] = 2'($urandom_range(0, 3));
      end
      sram_salt = 16'($urandom);
      cut = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 2*nw - 1) : -1;
      rk  = (cut >= 0) ? $urandom_range(0, 2) : 0;
      hb_txn(kind[0], kind[1], lin, a, nw, cut, rk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
